// File: rtl/router_pkg.sv
// Shared header layout, direction encodings and XY route computation for the mesh router.
// Header offsets are relative to the top 32 bits of a packet.
package router_pkg;

  localparam int HDR_W   = 32;
  localparam int HOP_W   = 4;
  localparam int HDR_VC  = 31;
  localparam int HDR_DX  = 30;
  localparam int HDR_DY  = 29;
  localparam int HDR_HX  = 20;
  localparam int HDR_HY  = 16;
  localparam int HDR_SRC = 0;

  localparam logic [4:0] DIR_E  = 5'b00001;
  localparam logic [4:0] DIR_W  = 5'b00010;
  localparam logic [4:0] DIR_N  = 5'b00100;
  localparam logic [4:0] DIR_S  = 5'b01000;
  localparam logic [4:0] DIR_PE = 5'b10000;

  typedef struct packed {
    logic [4:0]       req;
    logic [HDR_W-1:0] hdr;
  } route_t;

  // X hops are consumed before Y hops; the hop being taken is decremented in the returned header.
  function automatic route_t compute_route(input logic [HDR_W-1:0] hdr);
    route_t r;
    r.hdr = hdr;
    if (hdr[HDR_HX +: HOP_W] != '0) begin
      r.req = hdr[HDR_DX] ? DIR_W : DIR_E;
      r.hdr[HDR_HX +: HOP_W] = hdr[HDR_HX +: HOP_W] - HOP_W'(1);
    end else if (hdr[HDR_HY +: HOP_W] != '0) begin
      r.req = hdr[HDR_DY] ? DIR_S : DIR_N;
      r.hdr[HDR_HY +: HOP_W] = hdr[HDR_HY +: HOP_W] - HOP_W'(1);
    end else begin
      r.req = DIR_PE;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_input_port_vc_fifo.sv
// Circular-buffer FIFO for one virtual channel; any depth >= 1, occupancy kept in its own counter.
module vc_fifo #(
  parameter  int DATA_WIDTH   = 64,
  parameter  int BUFFER_DEPTH = 2,
  localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int              PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push, w_do_pop;

  assign full      = (r_count == CNT_W'(BUFFER_DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_port.sv
// Dual-VC router input port: polarity steers writes to one VC and reads/route requests to the other.
module router_input_port
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH   = 64,
  parameter  int BUFFER_DEPTH = 2,
  localparam int OCC_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  si,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  ri,
  output logic [4:0]            req,
  input  logic                  gnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OCC_W-1:0]      occ_even,
  output logic [OCC_W-1:0]      occ_odd,
  output logic                  err
);

  localparam int HDR_LSB = DATA_WIDTH - HDR_W;

  logic [1:0]            w_push, w_pop, w_full, w_empty;
  logic [DATA_WIDTH-1:0] w_head [2];
  logic [OCC_W-1:0]      w_count [2];
  logic [DATA_WIDTH-1:0] w_int_head;
  logic                  w_int_empty, w_send, w_vc_ok, w_pop_any;
  route_t                w_route;
  logic                  r_err;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .BUFFER_DEPTH(BUFFER_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[v]),
      .pop   (w_pop[v]),
      .din   (di),
      .full  (w_full[v]),
      .empty (w_empty[v]),
      .count (w_count[v]),
      .head  (w_head[v])
    );
  end

  // External VC is ~polarity, internal VC is polarity, so the two never collide.
  assign ri          = polarity ? !w_full[0] : !w_full[1];
  assign w_int_head  = polarity ? w_head[1] : w_head[0];
  assign w_int_empty = polarity ? w_empty[1] : w_empty[0];
  assign w_send      = si && ri;
  assign w_vc_ok     = (di[HDR_LSB + HDR_VC] == !polarity);
  assign w_push[0]   = w_send && w_vc_ok && polarity;
  assign w_push[1]   = w_send && w_vc_ok && !polarity;
  assign w_pop_any   = gnt && (req != '0);
  assign w_pop[0]    = w_pop_any && !polarity;
  assign w_pop[1]    = w_pop_any && polarity;
  assign w_route     = compute_route(w_int_head[DATA_WIDTH-1 -: HDR_W]);

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    req  = '0;
    dout = '0;
    if (!w_int_empty) begin
      req  = w_route.req;
      dout = {w_route.hdr, w_int_head[HDR_LSB-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_send && !w_vc_ok;
  end

  assign err      = r_err;
  assign occ_even = w_count[0];
  assign occ_odd  = w_count[1];

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: depth-2 and depth-3 instances share stimulus and are compared
// every cycle against a queue-based reference model, plus directed constant checks.
module tb_router_input_port;

  logic        clk = 1'b0;
  logic        reset, polarity, si, gnt;
  logic [63:0] di;

  logic        ri_a, err_a, ri_b, err_b;
  logic [4:0]  req_a, req_b;
  logic [63:0] dout_a, dout_b;
  logic [1:0]  oe_a, oo_a, oe_b, oo_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq [4][$];   // index = inst*2 + vc
  logic        m_err [2];
  int          m_depth [2] = '{2, 3};

  always #5 clk = ~clk;

  router_input_port #(.DATA_WIDTH(64), .BUFFER_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .di(di), .ri(ri_a),
    .req(req_a), .gnt(gnt), .dout(dout_a), .occ_even(oe_a), .occ_odd(oo_a), .err(err_a));

  router_input_port #(.DATA_WIDTH(64), .BUFFER_DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .di(di), .ri(ri_b),
    .req(req_b), .gnt(gnt), .dout(dout_b), .occ_even(oe_b), .occ_odd(oo_b), .err(err_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 4; q++) mq[q].delete();
    m_err[0] = 1'b0;
    m_err[1] = 1'b0;
  endtask

  // Reference behaviour at a clock edge, from the input-port rules.
  task automatic model_edge();
    if (reset) return;
    for (int i = 0; i < 2; i++) begin
      int ext = polarity ? 0 : 1;
      int inv = polarity ? 1 : 0;
      bit ready = mq[i*2+ext].size() < m_depth[i];
      m_err[i] = 1'b0;
      if (si && ready) begin
        if (int'(di[63]) == ext) mq[i*2+ext].push_back(di);
        else m_err[i] = 1'b1;
      end
      if (gnt && mq[i*2+inv].size() != 0) void'(mq[i*2+inv].pop_front());
    end
  endtask

  task automatic cmp_inst(input int i, input logic [4:0] r, input logic [63:0] d, input logic rdy,
                          input logic [1:0] oe, input logic [1:0] oo, input logic e);
    int          inv = polarity ? 1 : 0;
    int          ext = polarity ? 0 : 1;
    logic [4:0]  x_req = '0;
    logic [63:0] x_dout = '0;
    if (mq[i*2+inv].size() != 0) begin
      logic [63:0] h = mq[i*2+inv][0];
      int hx = int'(h[55:52]);
      int hy = int'(h[51:48]);
      if (hx != 0) begin
        x_req  = h[62] ? 5'd2 : 5'd1;
        x_dout = h - (64'd1 << 52);
      end else if (hy != 0) begin
        x_req  = h[61] ? 5'd8 : 5'd4;
        x_dout = h - (64'd1 << 48);
      end else begin
        x_req  = 5'd16;
        x_dout = h;
      end
    end
    check($sformatf("req%0d", i), r, x_req);
    check($sformatf("dout%0d", i), d, x_dout);
    check($sformatf("ri%0d", i), rdy, mq[i*2+ext].size() < m_depth[i]);
    check($sformatf("occ_even%0d", i), oe, mq[i*2].size());
    check($sformatf("occ_odd%0d", i), oo, mq[i*2+1].size());
    check($sformatf("err%0d", i), e, m_err[i]);
  endtask

  // Apply inputs in the low phase, then compare settled outputs against the model.
  task automatic drive(input logic s, input logic [63:0] d, input logic g);
    si = s; di = d; gnt = g;
    #1;
    cmp_inst(0, req_a, dout_a, ri_a, oe_a, oo_a, err_a);
    cmp_inst(1, req_b, dout_b, ri_b, oe_b, oo_b, err_b);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    polarity = ~polarity;
  endtask

  task automatic align(input logic p);
    if (polarity != p) begin
      drive(1'b0, 64'd0, 1'b0);
      tick();
    end
  endtask

  function automatic logic [63:0] rand_pkt(input logic vc);
    logic [63:0] d = {$urandom, $urandom};
    d[63] = vc;
    return d;
  endfunction

  initial begin
    logic [63:0] p;
    polarity = 1'b0; si = 1'b0; di = '0; gnt = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    drive(1'b0, 64'd0, 1'b0);
    check("rst_ri", ri_a, 1'b1);
    check("rst_req", req_a, 5'd0);
    tick();

    // Basic route west, then pop.
    align(1'b0);
    drive(1'b1, 64'hC010_0000_1111_1111, 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("west_req", req_a, 5'b00010);
    check("west_dout", dout_a, 64'hC000_0000_1111_1111);
    check("west_occ_before", oo_a, 2'd1);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    check("west_occ_after", oo_a, 2'd0);
    tick();

    // Route to PE on the even VC.
    align(1'b1);
    drive(1'b1, 64'h0000_0000_ABCD_1234, 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("pe_req", req_b, 5'b10000);
    check("pe_dout", dout_b, 64'h0000_0000_ABCD_1234);
    tick();

    // Route north once X is exhausted.
    align(1'b1);
    drive(1'b1, 64'h0003_5555_0000_0001, 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("north_req", req_a, 5'b00100);
    check("north_dout", dout_a, 64'h0002_5555_0000_0001);
    tick();

    // Full backpressure on the depth-2 instance.
    align(1'b0);
    drive(1'b1, rand_pkt(1'b1), 1'b0); tick();
    drive(1'b0, 64'd0, 1'b0);          tick();
    drive(1'b1, rand_pkt(1'b1), 1'b0); tick();
    drive(1'b0, 64'd0, 1'b0);          tick();
    drive(1'b1, rand_pkt(1'b1), 1'b0);
    check("full_ri", ri_a, 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("full_occ", oo_a, 2'd2);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    check("full_ri_freed", ri_a, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 64'd0, 1'b1);
      tick();
    end

    // VC/polarity mismatch: dropped, one-cycle err.
    align(1'b0);
    drive(1'b1, 64'h0100_0000_0000_0001, 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    check("mm_err", err_a, 1'b1);
    check("mm_occ", oe_a, 2'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    check("mm_err_clear", err_a, 1'b0);
    tick();

    // Asynchronous reset with one entry in each VC.
    align(1'b0);
    drive(1'b1, rand_pkt(1'b1), 1'b0); tick();
    drive(1'b1, rand_pkt(1'b0), 1'b0); tick();
    drive(1'b0, 64'd0, 1'b0);
    check("ar_pre_even", oe_b, 2'd1);
    check("ar_pre_odd", oo_b, 2'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_req", req_a, 5'd0);
    check("ar_dout", dout_a, 64'd0);
    check("ar_ri", ri_a, 1'b1);
    check("ar_occ_even", oe_a, 2'd0);
    check("ar_occ_odd", oo_b, 2'd0);
    model_reset();
    tick();
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    tick();

    // Pointer wrap: 7 in-order write/pop pairs on the odd VC.
    align(1'b0);
    for (int k = 0; k < 7; k++) begin
      p = rand_pkt(1'b1);
      p[55:48] = 8'h00;
      drive(1'b1, p, 1'b0);
      tick();
      drive(1'b0, 64'd0, 1'b1);
      check("wrap_dout", dout_b, p);
      tick();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic vc = (($urandom % 4) == 0) ? polarity : ~polarity;
      drive(1'($urandom % 2), rand_pkt(vc), 1'(($urandom % 3) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
